uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin front end for a UART transmitter whose ready
// flag lives in the baud clock domain; WR is held until ready is seen low.
module uart_tx_arbiter #(
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Req0,
    input  logic [7:0]  Data0,
    output logic        Ack0,
    input  logic        Req1,
    input  logic [7:0]  Data1,
    output logic        Ack1,
    input  logic        TxRDY,
    output logic        WR,
    output logic [31:0] Din,
    output logic        Busy,
    output logic        TimeoutErr
);

    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic          rdy_meta;
    logic          rdy_s;
    logic          last_gnt;
    logic          last_gnt_nx;
    logic          owner;
    logic          owner_nx;
    logic [7:0]    din_q;
    logic [7:0]    din_nx;
    logic          wr_nx;
    logic          ack0_nx;
    logic          ack1_nx;
    logic          err_nx;
    logic [CW-1:0] tcnt;
    logic [CW-1:0] tcnt_nx;
    logic [CW-1:0] tcnt_inc;
    logic          any_req;
    logic          pick;

    assign any_req  = Req0 | Req1;
    assign tcnt_inc = tcnt + 1'b1;
    assign Din      = {24'h0, din_q};

    // Ready crosses from the baud domain through two flops.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rdy_meta <= 1'b0;
            rdy_s    <= 1'b0;
        end else begin
            rdy_meta <= TxRDY;
            rdy_s    <= rdy_meta;
        end
    end

    always_comb begin
        pick = 1'b0;
        priority case (1'b1)
            Req0 & Req1: pick = ~last_gnt;
            Req1:        pick = 1'b1;
            default:     pick = 1'b0;
        endcase
    end

    always_comb begin
        state_nx    = state;
        wr_nx       = WR;
        din_nx      = din_q;
        owner_nx    = owner;
        last_gnt_nx = last_gnt;
        tcnt_nx     = tcnt;
        ack0_nx     = 1'b0;
        ack1_nx     = 1'b0;
        err_nx      = TimeoutErr;
        unique case (state)
            IDLE: begin
                if (rdy_s && any_req) begin
                    state_nx    = ISSUE;
                    wr_nx       = 1'b1;
                    din_nx      = pick ? Data1 : Data0;
                    owner_nx    = pick;
                    last_gnt_nx = pick;
                    tcnt_nx     = '0;
                end
            end
            ISSUE: begin
                // Ready falling means the transmitter took the byte.
                if (!rdy_s) begin
                    state_nx = WAIT_DONE;
                    wr_nx    = 1'b0;
                    ack0_nx  = ~owner;
                    ack1_nx  = owner;
                end else begin
                    tcnt_nx = tcnt_inc;
                    if (tcnt_inc == CW'(BUSY_TIMEOUT)) begin
                        state_nx = IDLE;
                        wr_nx    = 1'b0;
                        err_nx   = 1'b1;
                    end
                end
            end
            WAIT_DONE: begin
                if (rdy_s) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                wr_nx    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            WR         <= 1'b0;
            din_q      <= 8'h00;
            owner      <= 1'b0;
            last_gnt   <= 1'b1;
            tcnt       <= '0;
            Ack0       <= 1'b0;
            Ack1       <= 1'b0;
            Busy       <= 1'b0;
            TimeoutErr <= 1'b0;
        end else begin
            state      <= state_nx;
            WR         <= wr_nx;
            din_q      <= din_nx;
            owner      <= owner_nx;
            last_gnt   <= last_gnt_nx;
            tcnt       <= tcnt_nx;
            Ack0       <= ack0_nx;
            Ack1       <= ack1_nx;
            Busy       <= (state_nx != IDLE);
            TimeoutErr <= err_nx;
        end
    end

    a_one_ack: assert property (
        @(posedge Clock) disable iff (Reset) !(Ack0 && Ack1)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios and random traffic scored
// against a transaction-level reference model through an event queue.
module tb_uart_tx_arbiter;

    localparam int TO = 8;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Req0 = 1'b0;
    logic        Req1 = 1'b0;
    logic [7:0]  Data0 = 8'h00;
    logic [7:0]  Data1 = 8'h00;
    logic        TxRDY = 1'b1;
    logic        Ack0;
    logic        Ack1;
    logic        WR;
    logic [31:0] Din;
    logic        Busy;
    logic        TimeoutErr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    uart_tx_arbiter #(.BUSY_TIMEOUT(TO)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Req0       (Req0),
        .Data0      (Data0),
        .Ack0       (Ack0),
        .Req1       (Req1),
        .Data1      (Data1),
        .Ack1       (Ack1),
        .TxRDY      (TxRDY),
        .WR         (WR),
        .Din        (Din),
        .Busy       (Busy),
        .TimeoutErr (TimeoutErr)
    );

    always #5 Clock = ~Clock;

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    typedef logic [36:0] snap_t;
    typedef struct {
        snap_t v;
        int    at;
    } exp_t;

    exp_t q[$];

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h cyc=%0d", name, got, want, cyc);
        end
    endtask

    // Reference model: a transfer is open from grant until ready returns
    // after the hand-off, or until WR has been held TO cycles.
    bit       m_s1, m_s2, m_rdy;
    bit       m_open, m_sent, m_who;
    bit       m_rr = 1'b1;
    bit       m_wr, m_a0, m_a1, m_err;
    bit [7:0] m_byte;
    int       m_held;
    snap_t    m_last = '0;

    function automatic snap_t m_snap();
        return {m_wr, 24'h0, m_byte, m_a0, m_a1, m_open, m_err};
    endfunction

    initial forever begin
        @(posedge Clock or posedge Reset);
        if (Reset) begin
            m_s1 = 0; m_s2 = 0; m_open = 0; m_sent = 0; m_rr = 1;
            m_held = 0; m_wr = 0; m_a0 = 0; m_a1 = 0; m_err = 0;
            m_byte = 0;
        end else begin
            m_rdy = m_s2;
            m_s2 = m_s1;
            m_s1 = TxRDY;
            m_a0 = 0;
            m_a1 = 0;
            if (!m_open) begin
                if (m_rdy && (Req0 || Req1)) begin
                    m_who = (Req0 && Req1) ? !m_rr : Req1;
                    m_rr = m_who;
                    m_byte = m_who ? Data1 : Data0;
                    m_wr = 1; m_open = 1; m_sent = 0; m_held = 0;
                end
            end else if (m_sent) begin
                if (m_rdy) m_open = 0;
            end else if (!m_rdy) begin
                m_wr = 0;
                m_sent = 1;
                if (m_who) m_a1 = 1;
                else m_a0 = 1;
            end else begin
                m_held++;
                if (m_held == TO) begin
                    m_wr = 0; m_err = 1; m_open = 0;
                end
            end
        end
        if (m_snap() != m_last) begin
            m_last = m_snap();
            q.push_back('{m_last, cyc});
        end
    end

    // Monitor: every change of the output bundle must match the next
    // expected change, in the same cycle.
    snap_t prev = '0;
    snap_t obs;
    exp_t  e;

    initial forever begin
        @(negedge Clock);
        obs = {WR, Din, Ack0, Ack1, Busy, TimeoutErr};
        while (q.size() > 0 && q[0].at < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_change want=%h want_cyc=%0d cyc=%0d",
                     q[0].v, q[0].at, cyc);
            q.delete(0);
        end
        if (obs !== prev) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change got=%h was=%h cyc=%0d",
                         obs, prev, cyc);
            end else begin
                e = q.pop_front();
                if (e.v !== obs || e.at != cyc) begin
                    failures++;
                    $display("FAIL out_change got=%h want=%h cyc=%0d want_cyc=%0d",
                             obs, e.v, cyc, e.at);
                end
            end
            prev = obs;
        end
        checks++;
        if (Ack0 && Ack1) begin
            failures++;
            $display("FAIL ack_overlap got=11 want=not both cyc=%0d", cyc);
        end
        cyc++;
    end

    // Transmitter stand-in: drops ready some cycles after WR, keeps it low
    // for a character time; a stalled transfer never drops ready.
    bit auto_tx = 1'b1;
    bit tx_busy = 1'b0;
    int stall_pct = 0;

    initial forever begin
        @(negedge Clock);
        if (auto_tx && WR && TxRDY) begin
            tx_busy = 1;
            if ($urandom_range(99) < stall_pct) begin
                for (int i = 0; i < 20 && WR; i++) @(negedge Clock);
            end else begin
                repeat ($urandom_range(2)) @(negedge Clock);
                TxRDY = 0;
                repeat ($urandom_range(8, 4)) @(negedge Clock);
                TxRDY = 1;
            end
            tx_busy = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic wait_wr();
        for (int i = 0; i < 60; i++) begin
            @(negedge Clock);
            if (WR) break;
        end
        check("wr_seen", WR, 1);
    endtask

    task automatic wait_any_ack(output int who);
        who = -1;
        for (int i = 0; i < 80 && who < 0; i++) begin
            @(negedge Clock);
            if (Ack0) who = 0;
            else if (Ack1) who = 1;
        end
    endtask

    task automatic drain();
        int quiet = 0;
        for (int i = 0; i < 300 && quiet < 12; i++) begin
            @(negedge Clock);
            if (!Busy && !WR && TxRDY && !tx_busy) quiet++;
            else quiet = 0;
        end
        check("drain", quiet >= 12, 1);
    endtask

    task automatic pulse_reset();
        @(negedge Clock);
        Reset = 1;
        tick(2);
        Reset = 0;
    endtask

    initial begin
        int who;
        int n;
        bit saw;

        tick(1);
        check("reset_outputs", {WR, Din, Ack0, Ack1, Busy, TimeoutErr}, 0);
        tick(1);
        Reset = 0;

        // single request straight out of reset
        Req0 = 1;
        Data0 = 8'h41;
        wait_wr();
        check("single_din", Din, 32'h41);
        wait_any_ack(who);
        check("single_ack", who, 0);
        Req0 = 0;
        drain();
        check("single_busy", Busy, 0);

        // tie after reset alternates 0,1,0,1
        pulse_reset();
        Req0 = 1; Data0 = 8'h11;
        Req1 = 1; Data1 = 8'h22;
        for (int i = 0; i < 4; i++) begin
            wait_any_ack(who);
            check("tie_order", who, i % 2);
            check("tie_din", Din, (i % 2) ? 32'h22 : 32'h11);
        end
        Req0 = 0; Req1 = 0;
        drain();

        // not ready: nothing granted
        auto_tx = 0;
        TxRDY = 0;
        tick(3);
        Req1 = 1; Data1 = 8'h5a;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("not_ready_idle", {WR, Busy, Ack0, Ack1}, 0);
        end
        TxRDY = 1;
        auto_tx = 1;
        wait_any_ack(who);
        check("not_ready_grant", who, 1);
        Req1 = 0;
        drain();

        // timeout: ready never drops
        auto_tx = 0;
        Req0 = 1; Data0 = 8'($urandom);
        wait_wr();
        Req0 = 0;
        n = 0;
        saw = 0;
        while (WR && n < 40) begin
            n++;
            @(negedge Clock);
            if (Ack0 || Ack1) saw = 1;
        end
        check("timeout_len", n, TO);
        check("timeout_err", TimeoutErr, 1);
        check("timeout_no_ack", saw, 0);
        auto_tx = 1;
        Req1 = 1; Data1 = 8'($urandom);
        wait_any_ack(who);
        check("after_timeout", who, 1);
        Req1 = 0;
        drain();
        check("err_sticky", TimeoutErr, 1);

        // reset while WR is high
        auto_tx = 0;
        Req0 = 1; Data0 = 8'($urandom);
        wait_wr();
        tick(2);
        #2 Reset = 1;
        #1;
        check("reset_wr_async", WR, 0);
        check("reset_err", TimeoutErr, 0);
        check("reset_ack", {Ack0, Ack1}, 0);
        tick(2);
        Reset = 0;
        Req1 = 1;
        Data0 = 8'h33; Data1 = 8'h44;
        auto_tx = 1;
        wait_any_ack(who);
        check("post_reset_tie", who, 0);
        Req0 = 0; Req1 = 0;
        drain();

        // withdrawn request still completes
        Req0 = 1; Data0 = 8'($urandom);
        wait_wr();
        tick(1);
        Req0 = 0;
        wait_any_ack(who);
        check("withdrawn_ack", who, 0);
        drain();

        // random traffic with occasional stalled transfers
        stall_pct = 10;
        for (int c = 0; c < 1500; c++) begin
            @(negedge Clock);
            if (Ack0) begin
                Req0 = 1'($urandom_range(1));
                Data0 = 8'($urandom);
            end else if (!Req0 && $urandom_range(3) == 0) begin
                Req0 = 1;
                Data0 = 8'($urandom);
            end else if (Req0 && $urandom_range(31) == 0) begin
                Req0 = 0;
            end
            if (Ack1) begin
                Req1 = 1'($urandom_range(1));
                Data1 = 8'($urandom);
            end else if (!Req1 && $urandom_range(3) == 0) begin
                Req1 = 1;
                Data1 = 8'($urandom);
            end else if (Req1 && $urandom_range(31) == 0) begin
                Req1 = 0;
            end
        end
        Req0 = 0; Req1 = 0;
        drain();
        tick(4);
        check("queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
